// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry elastic register slice with valid/ready on both sides
module pipe_skid_buf #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   DEF_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_hs, out_hs;

  assign in_hs  = s_valid & s_ready;
  assign out_hs = m_valid & m_ready;
  assign m_data = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = DEF_VAL;
      skid_d  = DEF_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_hs) begin
            main_d  = s_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            main_d = s_data;
          end else if (in_hs) begin
            skid_d  = s_data;
            state_d = FULL;
          end else if (out_hs) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_hs) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs are flopped from the next state so m_ready never reaches s_ready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= DEF_VAL;
      skid_q  <= DEF_VAL;
      m_valid <= 1'b0;
      s_ready <= 1'b1;
      count   <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      m_valid <= (state_d != EMPTY);
      s_ready <= (state_d != FULL);
      count   <= (state_d == FULL) ? 2'd2 : ((state_d == ONE) ? 2'd1 : 2'd0);
    end
  end

endmodule
